// File: rtl/sqrt_request_arbiter_if.sv
// Bundle of the requester, core and result signals around sqrt_request_arbiter.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface sqrt_request_arbiter_if #(
  parameter int NUM_REQ           = 4,
  parameter int ID_WIDTH          = 2,
  parameter int INPUT_DATA_WIDTH  = 72,
  parameter int OUTPUT_DATA_WIDTH = 36
);
  logic [NUM_REQ-1:0]                  reqValid;
  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] reqData;
  logic [NUM_REQ-1:0]                  reqReady;
  logic                                sqrtEnable;
  logic [INPUT_DATA_WIDTH-1:0]         sqrtDataIn;
  logic [OUTPUT_DATA_WIDTH-1:0]        sqrtDataOut;
  logic                                resValid;
  logic [OUTPUT_DATA_WIDTH-1:0]        resData;
  logic [ID_WIDTH-1:0]                 resId;
  logic                                resReady;
  logic                                busy;

  modport slave (
    input  reqValid, reqData, sqrtDataOut, resReady,
    output reqReady, sqrtEnable, sqrtDataIn, resValid, resData, resId, busy
  );

  modport master (
    output reqValid, reqData, sqrtDataOut, resReady,
    input  reqReady, sqrtEnable, sqrtDataIn, resValid, resData, resId, busy
  );
endinterface

// File: rtl/sqrt_request_arbiter.sv
// Round-robin sharing of one square_root_cal core; the arbiter times the core's fixed
// latency itself and returns each root tagged with its requester id.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// reqReady is a one-hot strobe raised only in IDLE for the granted requester; resValid
// stays high with resData/resId frozen until the edge on which resReady is 1.
module sqrt_request_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int ID_WIDTH          = 2,
  parameter int INPUT_DATA_WIDTH  = 72,
  parameter int OUTPUT_DATA_WIDTH = 36,
  parameter int SQRT_LATENCY      = 37
) (
  input  logic                  clock,
  input  logic                  reset_n,
  sqrt_request_arbiter_if.slave bus,
  output logic [1:0]            fsm_state
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] RESULT  = 2'd2;
  localparam int CNT_W = $clog2(SQRT_LATENCY + 1);

  if (INPUT_DATA_WIDTH % 2 != 0) begin : g_bad_iw
    $error("INPUT_DATA_WIDTH must be even");
  end
  if (OUTPUT_DATA_WIDTH != INPUT_DATA_WIDTH / 2) begin : g_bad_ow
    $error("OUTPUT_DATA_WIDTH must equal INPUT_DATA_WIDTH/2");
  end
  if (ID_WIDTH < $clog2(NUM_REQ)) begin : g_bad_id
    $error("ID_WIDTH too small for NUM_REQ");
  end

  logic [1:0]          state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [CNT_W-1:0]    cnt;
  logic                grant_found;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [ID_WIDTH:0]   cand;
  logic [NUM_REQ-1:0]  ready_vec;

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_WIDTH + 1)'(k);
      if (cand >= (ID_WIDTH + 1)'(NUM_REQ)) cand = cand - (ID_WIDTH + 1)'(NUM_REQ);
      if (!grant_found && bus.reqValid[cand[ID_WIDTH-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_WIDTH-1:0];
      end
    end
  end

  // Gated by reset_n so the strobe is silent while reset is held.
  always_comb begin
    ready_vec = '0;
    if (reset_n && state == IDLE && grant_found) ready_vec[grant_idx] = 1'b1;
  end

  assign bus.reqReady = ready_vec;
  assign bus.busy     = (state != IDLE);
  assign fsm_state    = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      cnt            <= '0;
      bus.sqrtEnable <= 1'b0;
      bus.sqrtDataIn <= '0;
      bus.resValid   <= 1'b0;
      bus.resData    <= '0;
      bus.resId      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            bus.sqrtDataIn <= bus.reqData[int'(grant_idx) * INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
            bus.resId      <= grant_idx;
            cnt            <= '0;
            bus.sqrtEnable <= 1'b1;
            state          <= COMPUTE;
          end
        end
        COMPUTE: begin
          cnt <= cnt + 1'b1;
          // The core has no done flag; its output is trusted only after the full latency.
          if (cnt == CNT_W'(SQRT_LATENCY - 1)) begin
            bus.resData    <= bus.sqrtDataOut;
            bus.resValid   <= 1'b1;
            bus.sqrtEnable <= 1'b0;
            state          <= RESULT;
          end
        end
        RESULT: begin
          if (bus.resReady) begin
            bus.resValid <= 1'b0;
            rr_ptr       <= (bus.resId == ID_WIDTH'(NUM_REQ - 1)) ? '0 : bus.resId + 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sqrt_request_arbiter.sv
// Directed bench for sqrt_request_arbiter with a behavioural square-root core that only
// produces the correct root after SQRT_LATENCY enabled cycles on a stable operand.
module tb_sqrt_request_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int IW  = 72;
  localparam int OW  = 36;
  localparam int L   = 37;

  // clock / reset
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #10 clock = ~clock;

  sqrt_request_arbiter_if #(.NUM_REQ(N), .ID_WIDTH(IDW), .INPUT_DATA_WIDTH(IW),
                            .OUTPUT_DATA_WIDTH(OW)) bus ();
  logic [1:0] fsm_state;

  sqrt_request_arbiter #(.NUM_REQ(N), .ID_WIDTH(IDW), .INPUT_DATA_WIDTH(IW),
                         .OUTPUT_DATA_WIDTH(OW), .SQRT_LATENCY(L)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // core model: wrong output (all ones) until L enabled cycles on an unchanged operand
  function automatic logic [OW-1:0] isqrt(input logic [IW-1:0] x);
    logic [OW-1:0] r;
    logic [OW-1:0] t;
    r = '0;
    for (int b = OW - 1; b >= 0; b--) begin
      t = r | (OW'(1) << b);
      if (IW'(t) * IW'(t) <= x) r = t;
    end
    return r;
  endfunction

  int            core_k;
  logic [IW-1:0] core_held;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      core_k    <= 0;
      core_held <= '0;
    end else if (!bus.sqrtEnable) begin
      core_k <= 0;
    end else begin
      if (core_k == 0) core_held <= bus.sqrtDataIn;
      core_k <= core_k + 1;
    end
  end
  assign bus.sqrtDataOut = (bus.sqrtEnable && core_k >= L - 1 && bus.sqrtDataIn == core_held)
                           ? isqrt(bus.sqrtDataIn) : '1;

  // scoreboard
  int tests = 0;
  int fails = 0;
  logic [IDW+OW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int ch, input logic [IW-1:0] d);
    bus.reqValid[ch]          = 1'b1;
    bus.reqData[ch*IW +: IW]  = d;
  endtask

  task automatic clr_req(input int ch);
    bus.reqValid[ch] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Returns in the grant cycle (negedge + 1) with g = granted channel, or -1 on timeout.
  task automatic wait_grant(input int budget, output int g);
    g = -1;
    for (int i = 0; i < budget && g < 0; i++) begin
      #1;
      for (int c = 0; c < N; c++) if (bus.reqReady[c]) g = c;
      if (g < 0) @(negedge clock);
    end
    if (g < 0) check("grant_timeout", 0, 1);
  endtask

  // Counts cycles from the grant cycle to the first resValid cycle.
  task automatic wait_result(input int budget, output int n);
    n = 0;
    while (!bus.resValid && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (!bus.resValid) check("result_timeout", 0, 1);
  endtask

  task automatic score(input string tag);
    logic [IDW+OW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_id"}, bus.resId, e[IDW+OW-1:OW]);
      check({tag, "_data"}, bus.resData, e[OW-1:0]);
    end
  endtask

  // Single transaction with resReady=1: grant, latency, result, release.
  task automatic do_op(input string tag, input int ch, input logic [IW-1:0] d,
                       input logic [OW-1:0] root);
    int g;
    int n;
    exp_q.push_back({IDW'(ch), root});
    set_req(ch, d);
    wait_grant(100, g);
    check({tag, "_grant"}, g, ch);
    check({tag, "_onehot"}, bus.reqReady, N'(1) << ch);
    @(negedge clock);
    clr_req(ch);
    check({tag, "_ready_drop"}, bus.reqReady, 0);
    check({tag, "_enable"}, bus.sqrtEnable, 1);
    check({tag, "_operand"}, bus.sqrtDataIn, d);
    wait_result(L + 10, n);
    check({tag, "_latency"}, n + 1, L + 1);
    score(tag);
    @(negedge clock);
    check({tag, "_released"}, bus.resValid, 0);
  endtask

  initial begin
    int g;
    int n;
    int order[4];
    bit seen;

    bus.reqValid = '0;
    bus.reqData  = '0;
    bus.resReady = 1'b1;

    // reset state
    #5;
    check("rst_reqReady", bus.reqReady, 0);
    check("rst_sqrtEnable", bus.sqrtEnable, 0);
    check("rst_sqrtDataIn", bus.sqrtDataIn, 0);
    check("rst_resValid", bus.resValid, 0);
    check("rst_resData", bus.resData, 0);
    check("rst_resId", bus.resId, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_state", fsm_state, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // 1: single requester ch0
    @(negedge clock);
    do_op("t1", 0, 72'd45646, 36'd213);

    // 2: all four valid from reset, served in order 0..3
    @(negedge clock);
    reset_n = 1'b0;
    set_req(0, 72'd454536);
    set_req(1, 72'd258211);
    set_req(2, 72'd213247);
    set_req(3, 72'd25810);
    #1;
    check("t2_rst_ready_quiet", bus.reqReady, 0);
    exp_q.push_back({2'd0, 36'd674});
    exp_q.push_back({2'd1, 36'd508});
    exp_q.push_back({2'd2, 36'd461});
    exp_q.push_back({2'd3, 36'd160});
    @(negedge clock);
    reset_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_grant(100, g);
      check("t2_grant", g, r);
      @(negedge clock);
      if (g >= 0) clr_req(g);
      wait_result(L + 10, n);
      check("t2_latency", n + 1, L + 1);
      score("t2");
    end
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: result held while resReady=0; other requester must wait
    @(negedge clock);
    bus.resReady = 1'b0;
    set_req(1, 72'd5688);
    wait_grant(100, g);
    check("t3_grant", g, 1);
    @(negedge clock);
    clr_req(1);
    set_req(0, 72'd4);
    wait_result(L + 10, n);
    for (int c = 0; c < 20; c++) begin
      check("t3_hold_valid", bus.resValid, 1);
      check("t3_hold_data", bus.resData, 75);
      check("t3_hold_id", bus.resId, 1);
      check("t3_hold_ready", bus.reqReady, 0);
      check("t3_hold_enable", bus.sqrtEnable, 0);
      @(negedge clock);
    end
    bus.resReady = 1'b1;
    @(negedge clock);
    check("t3_idle_state", fsm_state, 0);
    check("t3_idle_ready", bus.reqReady, 4'b0001);
    exp_q.push_back({2'd0, 36'd2});
    @(negedge clock);
    clr_req(0);
    wait_result(L + 10, n);
    score("t3_next");

    // 4: ch0 and ch2 always valid -> alternate
    do_reset();
    set_req(0, 72'd86542);
    set_req(2, 72'd756787);
    order = '{0, 2, 0, 2};
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back({IDW'(order[r]), (order[r] == 0) ? 36'd294 : 36'd869});
      wait_grant(100, g);
      check("t4_grant", g, order[r]);
      @(negedge clock);
      wait_result(L + 10, n);
      score("t4");
      @(negedge clock);
    end
    clr_req(0);
    clr_req(2);

    // 5: reset in the middle of COMPUTE
    do_reset();
    set_req(2, 72'd756787);
    wait_grant(100, g);
    check("t5_grant", g, 2);
    @(negedge clock);
    clr_req(2);
    repeat (10) @(negedge clock);
    check("t5_busy_before", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_ready", bus.reqReady, 0);
    check("t5_rst_enable", bus.sqrtEnable, 0);
    check("t5_rst_datain", bus.sqrtDataIn, 0);
    check("t5_rst_valid", bus.resValid, 0);
    check("t5_rst_data", bus.resData, 0);
    check("t5_rst_id", bus.resId, 0);
    check("t5_rst_busy", bus.busy, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < L + 5; c++) begin
      @(negedge clock);
      if (bus.resValid) seen = 1'b1;
    end
    check("t5_no_late_valid", seen, 0);
    do_op("t5_ch3", 3, 72'd4, 36'd2);

    // 6: after ch3, the pointer wraps to 0
    do_op("t6_ch3", 3, 72'd123, 36'd11);
    set_req(0, 72'd4);
    set_req(3, 72'd123);
    wait_grant(100, g);
    check("t6_wrap_grant", g, 0);
    exp_q.push_back({2'd0, 36'd2});
    exp_q.push_back({2'd3, 36'd11});
    @(negedge clock);
    clr_req(0);
    wait_result(L + 10, n);
    score("t6_first");
    @(negedge clock);
    wait_grant(100, g);
    check("t6_second_grant", g, 3);
    @(negedge clock);
    clr_req(3);
    wait_result(L + 10, n);
    score("t6_second");
    check("t6_queue_empty", exp_q.size(), 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
